// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM state and port index.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic port_idx_t;

  localparam port_idx_t PORT0 = 1'b0;
  localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two client ports, the response path and the sync-RAM side.
interface dmem_arbiter_if #(
  parameter int WIDTH    = 16,
  parameter int D_ADDR_W = 8
);
  logic                req0, req1, wr0, wr1;
  logic [D_ADDR_W-1:0] addr0, addr1;
  logic [WIDTH-1:0]    wdata0, wdata1;
  logic                ack0, ack1;
  logic [WIDTH-1:0]    rdata;
  logic                mem_en, mem_wr;
  logic [D_ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata, mem_rdata;
  logic                busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational winner select between two requesters.
// DMEM_ARB_FIXED_PRIO_EN: port 0 always wins ties; otherwise round-robin on last grant.
module rr_picker
  import dmem_arb_pkg::*;
(
  input  logic      req0_i,
  input  logic      req1_i,
  input  port_idx_t last_grant_i,
  output port_idx_t idx_o
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_picker_in;
  assign unused_picker_in = req1_i ^ last_grant_i;
  assign idx_o = req0_i ? PORT0 : PORT1;
`else
  always_comb begin
    idx_o = PORT1;
    if (req0_i && req1_i) idx_o = ~last_grant_i;
    else if (req0_i)      idx_o = PORT0;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a synchronous data RAM: IDLE -> ACCESS -> RESP.
// Macro DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int D_ADDR_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  state_e              state_q, state_d;
  port_idx_t           idx_q, last_q, pick;
  logic                wr_q;
  logic [D_ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]    wdata_q;
  logic                any_req;

  assign any_req = bus.req0 | bus.req1;

  rr_picker u_pick (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_q),
    .idx_o        (pick)
  );

  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = any_req ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Requests are only looked at in IDLE; anything seen in ACCESS/RESP is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= PORT0;
      last_q  <= PORT1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        idx_q   <= pick;
        last_q  <= pick;
        wr_q    <= (pick == PORT0) ? bus.wr0    : bus.wr1;
        addr_q  <= (pick == PORT0) ? bus.addr0  : bus.addr1;
        wdata_q <= (pick == PORT0) ? bus.wdata0 : bus.wdata1;
      end
    end
  end

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_wr    = (state_q == ACCESS) && wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ack0      = (state_q == RESP) && (idx_q == PORT0);
  assign bus.ack1      = (state_q == RESP) && (idx_q == PORT1);
  assign bus.rdata     = (state_q == RESP && !wr_q) ? bus.mem_rdata : '0;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width.
REQ-002 Parameter D_ADDR_W, default 8, data-memory address width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Ports req0/req1  input  1 each  access request from port 0 (CPU datapath) and port 1 (loader/DMA).
REQ-006 Ports wr0/wr1  input  1 each  1 = write, 0 = read.
REQ-007 Ports addr0/addr1  input  D_ADDR_W each  request address.
REQ-008 Ports wdata0/wdata1  input  WIDTH each  write data.
REQ-009 Ports ack0/ack1  output  1 each  one-cycle completion pulse to the owning port.
REQ-010 Port rdata  output  WIDTH  read data; valid only in an ack cycle of a read.
REQ-011 Ports mem_en, mem_wr  output  1 each  memory enable and write strobe.
REQ-012 Ports mem_addr, mem_wdata  output  D_ADDR_W, WIDTH  registered memory address and data.
REQ-013 Port mem_rdata  input  WIDTH  synchronous-RAM read data, valid one cycle after mem_en.
REQ-014 Port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS, RESP, with transitions IDLE->ACCESS on any req, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-016 In IDLE with any req high, the arbiter SHALL pick a winner, latch its wr/addr/wdata and index, and enter ACCESS at the next edge.
REQ-017 In ACCESS, mem_en SHALL be 1, mem_wr SHALL equal the latched wr, and mem_addr/mem_wdata SHALL equal the latched values; outside ACCESS, mem_en and mem_wr SHALL be 0.
REQ-018 In RESP, exactly the winner's ack SHALL be 1, and for reads rdata SHALL equal mem_rdata; rdata SHALL be 0 in every other cycle.
REQ-019 Latency SHALL be fixed: req sampled at edge k, ACCESS during cycle k+1, ack during cycle k+2; peak throughput is one access per 3 cycles.
REQ-020 Default arbitration SHALL be round-robin: with both req high, the port not granted most recently wins; last-grant resets to port 1, so port 0 wins the first tie.
REQ-021 A req dropped after latching SHALL NOT abort the access; the memory cycle and ack still occur.
REQ-022 A req held high through its ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-023 Requests arriving in ACCESS or RESP SHALL be ignored until IDLE and SHALL NOT be latched.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, ack0=ack1=0, mem_en=mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, and last-grant=port 1.
REQ-026 A reset during ACCESS or RESP SHALL abandon the access with no ack; at most a partial memory write can result, and this is accepted.

Configuration
REQ-027 Macro DMEM_ARB_FIXED_PRIO_EN: when defined, port 0 SHALL always win ties and last-grant is unused; when undefined, round-robin per REQ-020 applies.

Structure
REQ-028 Package dmem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP) and the port-index typedef (1 bit).
REQ-029 Winner selection SHALL be a sub-module rr_picker (inputs req0, req1, last-grant; output index), combinational apart from the last-grant register kept in dmem_arbiter.

Verification
REQ-030 Single read: port 0 read at addr 0x10, memory holding 0xBEEF -> mem_en one cycle later with mem_addr=0x10, ack0 and rdata=0xBEEF two cycles after req.
REQ-031 Single write: port 1 write of 0x1234 to 0x20 -> one cycle with mem_en=1, mem_wr=1, mem_addr=0x20, mem_wdata=0x1234, then ack1; a later read of 0x20 returns 0x1234.
REQ-032 Contention: req0 and req1 held high for 12 cycles -> acks alternate ack0, ack1, ack0, ack1 at 3-cycle spacing; with DMEM_ARB_FIXED_PRIO_EN, only ack0 occurs.
REQ-033 Drop: req1 pulsed for one cycle only -> access completes and ack1 still pulses.
REQ-034 Reset in ACCESS: reset asserted mid-cycle -> outputs go to zero immediately, no ack appears, and the next request is served normally with port 0 winning the first tie.
